// File: rtl/hdc_msg_encoder.sv
// rtl/hdc_msg_encoder.sv - sequential trigram hypervector encoder for one captured message
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        encode request, sampled only while idle
//   msg          message bytes, char 0 in the most significant byte
//   length       number of valid characters (clamped to MAX_LEN)
//   hv_ready     downstream accepts hv_out
//   busy         high whenever the encoder is not idle
//   hv_valid     hv_out/ngram_count valid, held until accepted
//   hv_out       encoded query hypervector
//   ngram_count  number of trigrams bundled
module hdc_msg_encoder #(
    parameter int            D        = 1024,
    parameter int            CHAR_W   = 8,
    parameter int            MAX_LEN  = 200,
    parameter int            NGRAM    = 3,
    parameter int            ROT_STEP = 3,
    parameter logic [D-1:0]  SEED     = {
        128'h6A09_E667_BB67_AE85_3C6E_F372_A54F_F53A,
        128'h510E_527F_9B05_688C_1F83_D9AB_5BE0_CD19,
        128'h428A_2F98_7137_4491_B5C0_FBCF_E9B5_DBA5,
        128'h3956_C25B_59F1_11F1_923F_82A4_AB1C_5ED5,
        128'hD807_AA98_1283_5B01_2431_85BE_550C_7DC3,
        128'h72BE_5D74_80DE_B1FE_9BDC_06A7_C19B_F174,
        128'hE49B_69C1_EFBE_4786_0FC1_9DC6_240C_A1CC,
        128'h2DE9_2C6F_4A74_84AA_5CB0_A9DC_76F9_88DA}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CHAR_W*MAX_LEN-1:0] msg,
    input  logic [7:0]                length,
    input  logic                      hv_ready,
    output logic                      busy,
    output logic                      hv_valid,
    output logic [D-1:0]              hv_out,
    output logic [7:0]                ngram_count
);

    localparam int MW = CHAR_W * MAX_LEN;

    typedef enum logic [1:0] {IDLE, ACCUM, THRESH, DONE} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   msg_q, msg_d;
    logic [7:0]      index_q, index_d;
    logic [7:0]      ngram_q, ngram_d;
    logic            hv_valid_q, hv_valid_d;
    logic [D-1:0]    hv_out_q, hv_out_d;
    logic [7:0]      cnt_q [D];
    logic [7:0]      cnt_d [D];

    logic            clr, acc;
    logic [7:0]      len_eff, g_in;
    logic [D-1:0]    trigram, thr;

    function automatic logic [D-1:0] rotl(input logic [D-1:0] x, input int s);
        if (s == 0) return x;
        return (x << s) | (x >> (D - s));
    endfunction

    function automatic logic [D-1:0] item(input logic [CHAR_W-1:0] c);
        return rotl(SEED, (int'(c) * ROT_STEP) % D);
    endfunction

    // The message register shifts left one character per ACCUM cycle, so the
    // current trigram is always the top three characters.
    always_comb begin
        trigram = rotl(item(msg_q[MW-1 -: CHAR_W]), 2)
                ^ rotl(item(msg_q[MW-CHAR_W-1 -: CHAR_W]), 1)
                ^ item(msg_q[MW-2*CHAR_W-1 -: CHAR_W]);
    end

    always_comb begin
        len_eff = (int'(length) > MAX_LEN) ? 8'(MAX_LEN) : length;
        g_in    = (int'(len_eff) >= NGRAM) ? 8'(int'(len_eff) - (NGRAM - 1)) : 8'd0;
    end

    // Majority with ties to 0: 2*count > G, compared at 9 bits.
    always_comb begin
        thr = '0;
        for (int k = 0; k < D; k++) begin
            thr[k] = ({cnt_q[k], 1'b0} > {1'b0, ngram_q});
        end
    end

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        index_d    = index_q;
        ngram_d    = ngram_q;
        hv_valid_d = hv_valid_q;
        hv_out_d   = hv_out_q;
        clr        = 1'b0;
        acc        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    msg_d   = msg;
                    index_d = 8'd0;
                    ngram_d = g_in;
                    clr     = 1'b1;
                    state_d = (g_in != 8'd0) ? ACCUM : THRESH;
                end
            end
            ACCUM: begin
                acc     = 1'b1;
                msg_d   = msg_q << CHAR_W;
                index_d = index_q + 8'd1;
                if (index_q == ngram_q - 8'd1) state_d = THRESH;
            end
            THRESH: begin
                hv_out_d   = thr;
                hv_valid_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                if (hv_ready) begin
                    hv_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < D; k++) begin
            if (clr)      cnt_d[k] = 8'd0;
            else if (acc) cnt_d[k] = cnt_q[k] + {7'd0, trigram[k]};
            else          cnt_d[k] = cnt_q[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            msg_q      <= '0;
            index_q    <= 8'd0;
            ngram_q    <= 8'd0;
            hv_valid_q <= 1'b0;
            hv_out_q   <= '0;
            for (int k = 0; k < D; k++) cnt_q[k] <= 8'd0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            index_q    <= index_d;
            ngram_q    <= ngram_d;
            hv_valid_q <= hv_valid_d;
            hv_out_q   <= hv_out_d;
            for (int k = 0; k < D; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign busy        = (state_q != IDLE);
    assign hv_valid    = hv_valid_q;
    assign hv_out      = hv_out_q;
    assign ngram_count = ngram_q;

endmodule
